// File: rtl/nn_pkg.sv
// nn_pkg: shared widths, sum type and sequencer state encoding for the perceptron datapath.
package nn_pkg;
  localparam int DATA_W = 8;
  localparam int WEIGHT_W = 8;
  localparam int SUM_W = 11;
  typedef logic signed [SUM_W-1:0] sum_t;
  typedef enum logic [2:0] {IDLE, CLEAR, FETCH, DRAIN1, DRAIN2, OUT, FIN} seq_state_t;
endpackage

// File: rtl/nn_wrap_counter.sv
// nn_wrap_counter: up-counter that wraps to zero after TERM, with terminal-count flag.
module nn_wrap_counter #(
  parameter int W = 4,
  parameter int TERM = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clr,
  output logic [W-1:0] cnt,
  output logic         tc
);
  assign tc = cnt == W'(TERM);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt <= '0;
    else if (clr) cnt <= '0;
    else if (inc) cnt <= tc ? '0 : cnt + W'(1);
endmodule

// File: rtl/neuron_sequencer.sv
// neuron_sequencer: walks a layer's neurons, streams MAC operand addresses, hands sums downstream.
// Define NEURON_SEQ_RELU_EN to clamp negative captured sums to zero.
module neuron_sequencer #(
  parameter int NUM_INPUTS = 784,
  parameter int NUM_NEURONS = 10,
  parameter int SUM_W = nn_pkg::SUM_W,
  parameter int IN_AW = $clog2(NUM_INPUTS),
  parameter int W_AW = $clog2(NUM_INPUTS*NUM_NEURONS),
  parameter int NEU_W = $clog2(NUM_NEURONS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  output logic                    busy,
  output logic                    done,
  output logic [IN_AW-1:0]        in_addr,
  output logic [W_AW-1:0]         w_addr,
  output logic                    mem_rd,
  output logic                    pc_clear,
  output logic                    pc_en,
  input  logic signed [SUM_W-1:0] pc_sum,
  output logic                    res_valid,
  input  logic                    res_ready,
  output logic signed [SUM_W-1:0] res_sum,
  output logic [NEU_W-1:0]        res_idx
);
  import nn_pkg::*;
  seq_state_t state;
  logic [NEU_W-1:0] n;
  logic [W_AW-1:0] base;
  logic i_tc, n_tc, hs;
  logic signed [SUM_W-1:0] cap;
  assign hs = state == OUT && res_ready;
`ifdef NEURON_SEQ_RELU_EN
  assign cap = pc_sum[SUM_W-1] ? '0 : pc_sum;
`else
  assign cap = pc_sum;
`endif
  // the input counter doubles as the input-RAM address
  nn_wrap_counter #(.W(IN_AW), .TERM(NUM_INPUTS-1)) u_i (
    .clk(clk), .rst(rst), .inc(state == FETCH), .clr(state == CLEAR), .cnt(in_addr), .tc(i_tc)
  );
  nn_wrap_counter #(.W(NEU_W), .TERM(NUM_NEURONS-1)) u_n (
    .clk(clk), .rst(rst), .inc(hs), .clr(state == IDLE), .cnt(n), .tc(n_tc)
  );
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      busy <= 1'b0;
      done <= 1'b0;
      mem_rd <= 1'b0;
      pc_clear <= 1'b0;
      pc_en <= 1'b0;
      res_valid <= 1'b0;
      res_sum <= '0;
      res_idx <= '0;
      w_addr <= '0;
      base <= '0;
    end else begin
      pc_en <= mem_rd;
      pc_clear <= 1'b0;
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          state <= CLEAR;
          busy <= 1'b1;
          pc_clear <= 1'b1;
          base <= '0;
        end
        CLEAR: begin
          state <= FETCH;
          mem_rd <= 1'b1;
          w_addr <= base;
        end
        FETCH: begin
          w_addr <= i_tc ? w_addr : w_addr + W_AW'(1);
          mem_rd <= !i_tc;
          state <= i_tc ? DRAIN1 : FETCH;
        end
        DRAIN1: state <= DRAIN2;
        DRAIN2: begin
          state <= OUT;
          res_valid <= 1'b1;
          res_idx <= n;
          res_sum <= cap;
        end
        OUT: if (res_ready) begin
          res_valid <= 1'b0;
          state <= n_tc ? FIN : CLEAR;
          done <= n_tc;
          busy <= !n_tc;
          pc_clear <= !n_tc;
          base <= n_tc ? base : base + W_AW'(NUM_INPUTS);
        end
        FIN: state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_neuron_sequencer.sv
// tb_neuron_sequencer: table-driven check of the sequencer against a small RAM/ROM/MAC environment.
module tb_neuron_sequencer;
  localparam int NI = 4;
  localparam int NN = 2;
  logic clk = 1'b0;
  logic rst, start, busy, done, mem_rd, pc_clear, pc_en, res_valid, res_ready;
  logic [1:0] in_addr;
  logic [2:0] w_addr;
  logic signed [10:0] pc_sum, res_sum;
  logic [0:0] res_idx;
  logic signed [7:0] in_mem [NI];
  logic signed [7:0] w_mem [NI*NN];
  logic signed [7:0] d_q, w_q;
  logic signed [15:0] prod;
  logic signed [10:0] acc = '0;
  logic [2:0] w_log [1024];
  logic [1:0] i_log [1024];
  int rd_cnt = 0, en_cnt = 0, en_err = 0, done_cnt = 0, hs_cnt = 0;
  logic prev_rd = 1'b0;
  int checks = 0, errors = 0;
  typedef struct {
    logic signed [7:0] d, w0, w1;
    int s0, s1;
  } vec_t;
  vec_t vecs [4];

  always #5 clk = ~clk;

  neuron_sequencer #(.NUM_INPUTS(NI), .NUM_NEURONS(NN)) dut (
    .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
    .in_addr(in_addr), .w_addr(w_addr), .mem_rd(mem_rd), .pc_clear(pc_clear),
    .pc_en(pc_en), .pc_sum(pc_sum), .res_valid(res_valid), .res_ready(res_ready),
    .res_sum(res_sum), .res_idx(res_idx)
  );

  // memories with one-cycle read latency feeding a MAC that adds (d*w)>>>5
  assign prod = d_q * w_q;
  assign pc_sum = acc;
  always @(posedge clk) begin
    if (mem_rd) begin
      d_q <= in_mem[in_addr];
      w_q <= w_mem[w_addr];
    end
    if (pc_clear) acc <= '0;
    else if (pc_en) acc <= acc + 11'(prod >>> 5);
  end

  always @(posedge clk) begin
    if (!rst) prev_rd = 1'b0;
    else begin
      if (pc_en !== prev_rd) en_err++;
      prev_rd = mem_rd;
      if (mem_rd) begin
        w_log[rd_cnt] = w_addr;
        i_log[rd_cnt] = in_addr;
        rd_cnt++;
      end
      if (pc_en) en_cnt++;
      if (done) done_cnt++;
      if (res_valid && res_ready) hs_cnt++;
    end
  end

  function automatic int ex(int s);
`ifdef NEURON_SEQ_RELU_EN
    return s < 0 ? 0 : s;
`else
    return s;
`endif
  endfunction

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic load(vec_t v);
    for (int i = 0; i < NI; i++) begin
      in_mem[i] = v.d;
      w_mem[i] = v.w0;
      w_mem[NI+i] = v.w1;
    end
  endtask

  task automatic run_pass(int s0, int s1, bit hold, bit repulse);
    int rd0, en0, err0, dn0, hs0, bad;
    rd0 = rd_cnt; en0 = en_cnt; err0 = en_err; dn0 = done_cnt; hs0 = hs_cnt;
    res_ready = !hold;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("busy_after_start", busy, 1);
    for (int k = 0; k < NN; k++) begin
      int t = 0;
      while (!res_valid && t < 50) begin
        @(negedge clk);
        t++;
        start = repulse && (t == 2 || t == 5);
      end
      start = 1'b0;
      chk("latency", t, 7);
      chk("res_sum", int'(res_sum), ex(k == 0 ? s0 : s1));
      chk("res_idx", int'(res_idx), k);
      if (hold && k == 0) begin
        bad = 0;
        for (int c = 0; c < 10; c++) begin
          @(negedge clk);
          if (!res_valid || int'(res_sum) != ex(s0) || res_idx != 1'b0 || mem_rd) bad++;
        end
        chk("hold_stable", bad, 0);
        res_ready = 1'b1;
      end
      @(negedge clk);
      chk("valid_fall", res_valid, 0);
    end
    chk("done_high", done, 1);
    chk("busy_low", busy, 0);
    @(negedge clk);
    chk("done_pulse", done, 0);
    chk("rd_count", rd_cnt - rd0, NI*NN);
    chk("en_count", en_cnt - en0, NI*NN);
    chk("en_align", en_err - err0, 0);
    chk("done_count", done_cnt - dn0, 1);
    chk("hs_count", hs_cnt - hs0, NN);
    bad = 0;
    for (int j = 0; j < NI*NN; j++)
      if (int'(w_log[rd0+j]) != j || int'(i_log[rd0+j]) != j % NI) bad++;
    chk("addr_trace", bad, 0);
  endtask

  initial begin
    int rd0, dn0;
    vecs[0] = '{d: 8'sd32, w0: 8'sd32, w1: 8'sd32, s0: 128, s1: 128};
    vecs[1] = '{d: 8'sd32, w0: 8'sd16, w1: -8'sd32, s0: 64, s1: -128};
    vecs[2] = '{d: -8'sd64, w0: 8'sd32, w1: 8'sd64, s0: -256, s1: -512};
    vecs[3] = '{d: 8'sd1, w0: 8'sd31, w1: 8'sd32, s0: 0, s1: 4};
    rst = 1'b0;
    start = 1'b0;
    res_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_outs", int'(|{busy, done, mem_rd, pc_clear, pc_en, res_valid, res_sum, res_idx, in_addr, w_addr}), 0);
    rst = 1'b1;
    for (int v = 0; v < 4; v++) begin
      load(vecs[v]);
      run_pass(vecs[v].s0, vecs[v].s1, 1'b0, 1'b0);
    end
    load(vecs[2]);
    run_pass(vecs[2].s0, vecs[2].s1, 1'b1, 1'b0);
    load(vecs[1]);
    run_pass(vecs[1].s0, vecs[1].s1, 1'b0, 1'b1);
    rd0 = rd_cnt;
    repeat (10) @(negedge clk);
    chk("idle_after_repulse", rd_cnt - rd0 + int'(busy), 0);
    load(vecs[0]);
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    repeat (2) @(negedge clk);
    chk("mid_fetch_rd", mem_rd, 1);
    dn0 = done_cnt;
    #1 rst = 1'b0;
    #1 chk("reset_mid_outs", int'(|{busy, done, mem_rd, pc_clear, pc_en, res_valid, res_sum, res_idx, in_addr, w_addr}), 0);
    repeat (5) @(negedge clk);
    chk("reset_no_done", done_cnt - dn0 + int'(busy), 0);
    rst = 1'b1;
    run_pass(vecs[0].s0, vecs[0].s1, 1'b0, 1'b0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got running expected finished");
    $fatal(1);
  end
endmodule

// File: doc/neuron_sequencer.md
Name: neuron_sequencer

Overview:
Control stage directly upstream of the perceptron MAC. Walks all neurons of one layer in order; for each neuron it clears the MAC, streams NUM_INPUTS addresses to the input-activation RAM and weight ROM, and asserts the MAC enable aligned to the returning read data. It then captures the finished 11-bit sum and offers it downstream on a valid/ready handshake.

Parameters:
NUM_INPUTS, 784, products accumulated per neuron
NUM_NEURONS, 10, neurons processed per start
SUM_W, 11, MAC sum width (signed)
IN_AW, $clog2(NUM_INPUTS), input RAM address width
W_AW, $clog2(NUM_INPUTS*NUM_NEURONS), weight ROM address width
NEU_W, $clog2(NUM_NEURONS), neuron index width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-low reset
start  in  1  one-cycle pulse; begins a layer pass when idle
busy  out  1  high from accepted start until done
done  out  1  one-cycle pulse after the last result handshake
in_addr  out  IN_AW  input-activation RAM read address
w_addr  out  W_AW  weight ROM read address
mem_rd  out  1  read strobe to both memories (1-cycle read latency)
pc_clear  out  1  MAC clear
pc_en  out  1  MAC accumulate enable
pc_sum  in  SUM_W  signed MAC sum
res_valid  out  1  result available
res_ready  in  1  downstream accepts result
res_sum  out  SUM_W  signed captured sum
res_idx  out  NEU_W  neuron index of res_sum

Behaviour:
- Reset (rst=0, asynchronous): state IDLE. All outputs 0, all counters 0. A reset mid-pass abandons the pass, and no done pulse is issued.
- States: IDLE, CLEAR, FETCH, DRAIN1, DRAIN2, OUT, FIN.
- IDLE: on start=1 go to CLEAR and set busy=1. Neuron counter n=0, weight base=0.
- CLEAR: pc_clear=1 for one cycle. Input counter i=0. Next state FETCH.
- FETCH: mem_rd=1, in_addr=i, w_addr=base+i.
  - i increments each cycle.
  - When i=NUM_INPUTS-1 is issued, go to DRAIN1.
  - No stalls inside FETCH.
- pc_en is mem_rd delayed by one register, so it is high exactly NUM_INPUTS cycles, aligned with read data.
- DRAIN1: pc_en high for the final product.
- DRAIN2: pc_sum now reflects all products. Capture pc_sum into res_sum, set res_idx=n, res_valid=1. Next state OUT.
- OUT: hold res_sum, res_idx and res_valid stable until res_ready=1.
  - On handshake with n<NUM_NEURONS-1: n++, base+=NUM_INPUTS, go to CLEAR.
  - On handshake with n=NUM_NEURONS-1: go to FIN.
  - res_valid falls in the cycle after the handshake.
- FIN: done=1 for one cycle, busy=0, return to IDLE.
- Latency per neuron with res_ready held high: 1 (CLEAR) + NUM_INPUTS + 2 drain cycles + 1 OUT cycle.
- start while busy is ignored.
- res_ready while res_valid=0 is ignored.
- Weight address is produced by an incrementing base (no multiplier). base never exceeds (NUM_NEURONS-1)*NUM_INPUTS.
- No arithmetic on the sum in the default build; res_sum equals pc_sum bit-exact.

Optional Feature:
NEURON_SEQ_RELU_EN:
- Defined: the captured value is ReLU'd, i.e. res_sum = (pc_sum<0) ? 0 : pc_sum.
- Undefined: res_sum = pc_sum unchanged.
- Handshake and timing are identical in both builds.

Decomposition:
- Shared package nn_pkg holds:
  - DATA_W=8, WEIGHT_W=8, SUM_W=11
  - typedef logic signed [SUM_W-1:0] sum_t
  - seq_state_t enum {IDLE, CLEAR, FETCH, DRAIN1, DRAIN2, OUT, FIN}
- One natural sub-module: nn_wrap_counter (parameterised width and terminal value, with inc/clr and a terminal-count flag), used for both i and n.

Test Plan:
- NUM_INPUTS=4, NUM_NEURONS=2, all data=32, all weights=32, res_ready=1 → each neuron's res_sum=128 (4×(1024>>5)); res_idx 0 then 1; done one cycle after the second handshake.
- Address trace, NUM_INPUTS=4 → w_addr sequence 0,1,2,3 then 4,5,6,7; pc_en high exactly 4 cycles per neuron, starting one cycle after the first mem_rd.
- res_ready held 0 for 10 cycles in OUT → res_valid, res_sum and res_idx stable; no new mem_rd; resumes on the ready edge.
- Negative sum: data=-64, weight=32 (-2048>>5 = -64 per product, 4 products) → res_sum=-256 without NEURON_SEQ_RELU_EN; res_sum=0 with it.
- rst pulled low mid-FETCH → all outputs 0 immediately, no done; a new start afterwards runs a full clean pass.
- start re-pulsed while busy → ignored; exactly NUM_NEURONS results and a single done.
